shift_register_universal: RTL
=============================

Name: shift_register_universal

Overview:
Parametrised successor to the team's 8-bit load/shift register. Adds a generic width, four shift/rotate modes, a serial in/out pair, and an autonomous burst engine that performs N shifts from one start strobe with busy/done handshake. Sits in datapaths needing serialisation or barrel-like stepping under FSM control.

Parameters:
WIDTH, 8, register width in bits (≥2)
CNT_W, $clog2(WIDTH+1), width of burst_len; derived, not overridden

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-low reset (asserted when 0)
load_en  in  1  parallel load of data_in
data_in  in  WIDTH  parallel load value
shift_en  in  1  single-step shift using current mode
mode  in  2  0=SLL, 1=SRL, 2=ROL, 3=ROR
serial_in  in  1  fill bit for SLL/SRL (ignored for rotates)
burst_start  in  1  start autonomous burst
burst_len  in  CNT_W  number of shifts in burst
data_out  out  WIDTH  register contents
serial_out  out  1  bit expelled/wrapped by most recent shift
busy  out  1  burst in progress
done  out  1  one-cycle pulse on burst completion
zero  out  1  combinational data_out == 0

Behaviour:
- Reset (rst=0 at edge): data_out=0, serial_out=0, busy=0, done=0, FSM=IDLE, counter=0. Reset overrides everything, including a running burst (no done pulse).
- Priority per edge: reset > load_en > running burst > burst_start > shift_en.
- SLL: {q[W-2:0],serial_in}, out=q[W-1]. SRL: {serial_in,q[W-1:1]}, out=q[0]. ROL: {q[W-2:0],q[W-1]}, out=q[W-1]. ROR: {q[0],q[W-1:1]}, out=q[0].
- load_en: data_out←data_in, serial_out←0; if busy, burst aborts: busy←0, no done pulse.
- shift_en in IDLE: one shift per edge. Ignored while busy.
- FSM IDLE/RUN. burst_start at edge k (IDLE, no load_en): mode latched, count←min(burst_len, WIDTH); busy←1 at edge k if count≥1. Shifts occur at edges k+1..k+count; at edge k+count busy←0, done←1. done clears at the next edge.
- burst_len=0: no shift, busy stays 0, done←1 at edge k.
- burst_len>WIDTH saturates to WIDTH.
- mode/serial_in changes during RUN: mode ignored (latched); serial_in sampled live.
- burst_start while busy ignored. In the done cycle, the block is IDLE and accepts any input.
- All outputs registered except zero.

Decomposition:
- Package shreg_pkg: shift_mode_e enum (SH_SLL, SH_SRL, SH_ROL, SH_ROR), state_e enum (S_IDLE, S_RUN).
- Sub-module shreg_step (combinational, WIDTH param): inputs q, mode, serial_in; outputs q_next, out_bit. Shared by single-step and burst paths.
- Top contains the FSM, burst counter and register.

Test Plan:
- Reset: rst=0 for 2 cycles with load_en=1, data_in=8'hFF → data_out=0, busy=0, done=0, serial_out=0, zero=1.
- Single-step SRL: load 8'h80, mode=1, serial_in=0, shift_en for 7 edges → 8'h01. One more edge → 8'h00, serial_out=1, zero=1.
- Burst ROL: load 8'hA1, burst_start with len=4, mode=2 → busy for 4 cycles, data_out=8'h1A, serial_out=0, done high exactly 1 cycle. Toggling mode and shift_en mid-burst has no effect.
- SLL fill: load 8'h00, serial_in=1, burst len=3, mode=0 → 8'h07, serial_out=0.
- Abort and reset: ROR burst len=8 on 8'h01; load_en with 8'h55 on 3rd busy cycle → data_out=8'h55, busy=0, no done. Repeat with rst=0 mid-burst → all outputs zero, no done.
- Boundaries: len=0 → done pulse next edge, data unchanged, busy never high. len=15 on 8'h3C ROR → exactly 8 busy cycles, final 8'h3C.

Source files
------------

// File: rtl/shreg_pkg.sv
// Shared types for the universal shift register: shift modes and burst FSM states.
package shreg_pkg;

   typedef enum logic [1:0] {
      SH_SLL = 2'd0,
      SH_SRL = 2'd1,
      SH_ROL = 2'd2,
      SH_ROR = 2'd3
   } shift_mode_e;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/shreg_step.sv
// One combinational shift/rotate step; shared by the single-step and burst paths.
module shreg_step
   import shreg_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] i_q,
   input  shift_mode_e      i_mode,
   input  logic             i_serial_in,
   output logic [WIDTH-1:0] o_q_next,
   output logic             o_out_bit
);

   always_comb begin
      o_q_next  = i_q;
      o_out_bit = 1'b0;
      unique case (i_mode)
         SH_SLL: begin
            o_q_next  = {i_q[WIDTH-2:0], i_serial_in};
            o_out_bit = i_q[WIDTH-1];
         end
         SH_SRL: begin
            o_q_next  = {i_serial_in, i_q[WIDTH-1:1]};
            o_out_bit = i_q[0];
         end
         SH_ROL: begin
            o_q_next  = {i_q[WIDTH-2:0], i_q[WIDTH-1]};
            o_out_bit = i_q[WIDTH-1];
         end
         SH_ROR: begin
            o_q_next  = {i_q[0], i_q[WIDTH-1:1]};
            o_out_bit = i_q[0];
         end
         default: begin
            o_q_next  = i_q;
            o_out_bit = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/shift_register_universal.sv
// Parametrised universal shift register with load, single-step shifts and an
// autonomous N-shift burst engine reporting busy/done.
module shift_register_universal
   import shreg_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_en,
   input  logic [WIDTH-1:0] data_in,
   input  logic             shift_en,
   input  logic [1:0]       mode,
   input  logic             serial_in,
   input  logic             burst_start,
   input  logic [CNT_W-1:0] burst_len,
   output logic [WIDTH-1:0] data_out,
   output logic             serial_out,
   output logic             busy,
   output logic             done,
   output logic             zero
);

   state_e           r_state, w_state_d;
   shift_mode_e      r_mode, w_mode_d;
   logic [CNT_W-1:0] r_cnt, w_cnt_d;
   logic [WIDTH-1:0] r_data, w_data_d;
   logic             r_sout, w_sout_d;
   logic             r_done, w_done_d;

   shift_mode_e      w_step_mode;
   logic [WIDTH-1:0] w_step_q;
   logic             w_step_out;
   logic [CNT_W-1:0] w_len_sat;

   // A running burst uses the mode latched at start; idle steps use the live mode.
   assign w_step_mode = (r_state == S_RUN) ? r_mode : shift_mode_e'(mode);
   assign w_len_sat   = (burst_len > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : burst_len;

   shreg_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .i_q         (r_data),
      .i_mode      (w_step_mode),
      .i_serial_in (serial_in),
      .o_q_next    (w_step_q),
      .o_out_bit   (w_step_out)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_mode  <= SH_SLL;
         r_cnt   <= '0;
         r_data  <= '0;
         r_sout  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_mode  <= w_mode_d;
         r_cnt   <= w_cnt_d;
         r_data  <= w_data_d;
         r_sout  <= w_sout_d;
         r_done  <= w_done_d;
      end
   end

   always_comb begin
      w_state_d = r_state;
      w_mode_d  = r_mode;
      w_cnt_d   = r_cnt;
      w_data_d  = r_data;
      w_sout_d  = r_sout;
      w_done_d  = 1'b0;
      if (load_en) begin
         w_data_d  = data_in;
         w_sout_d  = 1'b0;
         w_state_d = S_IDLE;
         w_cnt_d   = '0;
      end else if (r_state == S_RUN) begin
         w_data_d = w_step_q;
         w_sout_d = w_step_out;
         w_cnt_d  = r_cnt - CNT_W'(1);
         if (r_cnt == CNT_W'(1)) begin
            w_state_d = S_IDLE;
            w_done_d  = 1'b1;
         end
      end else if (burst_start) begin
         w_mode_d = shift_mode_e'(mode);
         w_cnt_d  = w_len_sat;
         if (w_len_sat == '0) begin
            w_done_d = 1'b1;
         end else begin
            w_state_d = S_RUN;
         end
      end else if (shift_en) begin
         w_data_d = w_step_q;
         w_sout_d = w_step_out;
      end
   end

   always_comb begin
      data_out   = r_data;
      serial_out = r_sout;
      busy       = (r_state == S_RUN);
      done       = r_done;
      zero       = (r_data == '0);
   end

endmodule
